keypad_event_ctrl: RTL and testbench
====================================

# keypad_event_ctrl

Debounces the raw 16-bit key-state vector from the keypad column scanner and turns each clean single-key press into one 4-bit key-code event. Events queue in a small FIFO and leave through a valid/ready handshake to the consumer (display, entry or calculator logic). The block sits between the scanner and all key consumers; no consumer reads `keys` directly.

## Interface
- `DIV`, 50_000: clk cycles per sample tick (1 ms at 50 MHz); must be ≥2.
- `STABLE_TICKS`, 4: consecutive identical ticks needed to accept a press or a release; must be ≥2.
- `DEPTH`, 4: event FIFO depth; must be a power of 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `keys`  in  16  key states from the scanner; bit k high = key with hex value k is pressed.
- `key_valid`  out  1  FIFO non-empty.
- `key_code`  out  4  FIFO head code; 0 whenever `key_valid`=0.
- `key_ready`  in  1  consumer pops the head on a cycle where `key_valid & key_ready`.
- `held`  out  1  an accepted key is still down (HELD or RELEASE_WAIT).
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Tick counter runs 0..DIV-1. `tick` is high for one cycle when the count is DIV-1; the counter then wraps to 0. Sampling and FSM transitions happen only on tick cycles.
- Sample class on a tick:
  - NONE: `keys`=0.
  - SINGLE(c): exactly one bit set, c = its index.
  - MULTI: two or more bits set.
- FSM, with a 4-bit candidate `cand` and a debounce counter `cnt`:
  - IDLE: on SINGLE(c): `cand`=c, `cnt`=1, go to PRESS_WAIT. Stay in IDLE otherwise.
  - PRESS_WAIT: on SINGLE(`cand`):
    - if `cnt`=STABLE_TICKS-1, push `cand` and go to HELD;
    - otherwise `cnt`++.
    - Any other class (NONE, MULTI, a different key) returns to IDLE with no event.
  - HELD: on NONE: `cnt`=1, go to RELEASE_WAIT. Stay in HELD otherwise; MULTI or rollover while held produces no event.
  - RELEASE_WAIT: on NONE:
    - if `cnt`=STABLE_TICKS-1, go to IDLE;
    - otherwise `cnt`++.
    - Any key returns to HELD.
- A held key produces exactly one event. There is no auto-repeat.
- FIFO behaviour:
  - Push with FIFO full and no pop in the same cycle: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle with FIFO full: both succeed, no overflow.
  - Push into an empty FIFO: normal.
  - Order is strictly first-in, first-out. Pointers wrap modulo DEPTH.
- `overflow`: `ovf_clr` clears it. If `ovf_clr` and a drop occur in the same cycle, `overflow` ends up set (set wins).
- Reset mid-operation:
  - FSM returns to IDLE, FIFO empties, all counters clear.
  - A key still down after reset is treated as a fresh press and generates a new event after debounce.

## Timing
- Reset values:
  - `key_valid`=0, `key_code`=0, `held`=0, `overflow`=0.
  - Tick counter=0, FSM=IDLE.
- First tick occurs DIV-1 cycles after the cycle `rst` deasserts.
- Press-to-event latency is STABLE_TICKS ticks.
  - The push happens on the tick cycle where the final matching sample is taken.
  - `key_valid` and `key_code` update on the following clk edge, i.e. 1 cycle after that tick.
- `held` rises on the same edge as the push and falls on the edge that enters IDLE.
- Pop takes effect at the clk edge. The next head, or `key_valid`=0, is visible in the next cycle.
- `key_valid` never depends combinationally on `key_ready`.

## Structure
- Shared package `keypad_pkg` holds:
  - FSM state encodings: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - `NKEYS`=16 and `CODE_W`=4.
  - The one-hot-to-code / class function.
- One sub-module, `keypad_event_fifo`: a synchronous FIFO parameterised by DEPTH and width, exposing full/empty plus push/pop.
- The tick counter, classifier and FSM live in the top module.

## Test plan
All scenarios use DIV=4, STABLE_TICKS=3, DEPTH=4.
- Reset: hold `rst` high with `keys`=16'h0020 → all outputs 0. After release, no event until 3 ticks have elapsed.
- Clean press: `keys`=16'h0020 held for 3 ticks with `key_ready`=1 → `key_valid` high for exactly 1 cycle with `key_code`=5; `held`=1. Then `keys`=0 for 3 ticks → `held`=0.
- Bounce: `keys`=16'h0020 for 2 ticks, 0 for 1 tick, 16'h0020 for 2 ticks → no event.
- Multi-key: `keys`=16'h0006 for 10 ticks → no event; `held`=0.
- Overflow: `key_ready`=0, five clean press/release cycles with codes 1,2,3,4,5 → FIFO holds 1,2,3,4 and `overflow`=1. Pulse `ovf_clr` → `overflow`=0. Set `key_ready`=1 → codes pop in order 1,2,3,4.
- Reset mid-hold: key A held and `held`=1, pulse `rst` → FIFO empty and `held`=0. Keep A pressed → a new event with `key_code`=10 after 3 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, constants and the key-sample classifier for the
//             keypad event controller.
//  Contents : NKEYS / CODE_W constants, FSM state encoding, sample class
//             encoding, classify_keys() helper.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

  localparam int NKEYS  = 16;
  localparam int CODE_W = 4;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

  // Classification of one sample of the key vector.
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } key_class_e;

  typedef struct packed {
    key_class_e          cls;
    logic [CODE_W-1:0]   code;
  } key_sample_t;

  // Classify a raw key vector. The code field is only meaningful when the
  // class is CLS_SINGLE; it is forced to zero otherwise so downstream logic
  // never sees a stale or arbitrary index.
  function automatic key_sample_t classify_keys(input logic [NKEYS-1:0] keys);
    key_sample_t      s;
    int unsigned      n;
    logic [CODE_W-1:0] last;
    n    = 0;
    last = '0;
    for (int k = 0; k < NKEYS; k++) begin
      if (keys[k]) begin
        n    = n + 1;
        last = CODE_W'(k);
      end
    end
    s.code = '0;
    if (n == 0) begin
      s.cls = CLS_NONE;
    end else if (n == 1) begin
      s.cls  = CLS_SINGLE;
      s.code = last;
    end else begin
      s.cls = CLS_MULTI;
    end
    return s;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_event_fifo
//  Purpose  : Small synchronous FIFO for key-code events. Flags are derived
//             from a registered occupancy count, so empty/full never depend
//             combinationally on push/pop.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, din       - write request and data
//             pop             - read request (ignored when empty)
//             dout            - head entry (undefined content when empty)
//             full, empty     - occupancy flags
//  Notes    : DEPTH must be a power of two and >= 2; pointers wrap naturally.
//             A push while full is accepted only if a pop happens in the same
//             cycle; otherwise it is ignored (the caller flags the drop).
//  Revision : 1.0  initial release
// ============================================================================
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : keypad_event_fifo
`default_nettype wire

// File: rtl/keypad_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_event_ctrl
//  Purpose  : Debounces the raw 16-bit key vector and emits one 4-bit code
//             per clean single-key press through a valid/ready event FIFO.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             keys[15:0]      - raw key states, bit k = key k pressed
//             key_valid       - event FIFO non-empty
//             key_code[3:0]   - head event code, 0 when key_valid is low
//             key_ready       - consumer pops head when key_valid & key_ready
//             held            - an accepted key is still down
//             overflow        - sticky, an event was dropped on a full FIFO
//             ovf_clr         - clears overflow (a same-cycle drop wins)
//  Params   : DIV (>=2) clk cycles per sample tick, STABLE_TICKS (>=2)
//             matching ticks to accept press/release, DEPTH (power of 2).
//  Revision : 1.0  initial release
// ============================================================================
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int DIV          = 50_000,
  parameter int STABLE_TICKS = 4,
  parameter int DEPTH        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  keys,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              held,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int TICK_W = $clog2(DIV);
  localparam int CNT_W  = $clog2(STABLE_TICKS);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_TICKS - 1);

  // --------------------------------------------------------------------------
  // Sample tick
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sample classification
  // --------------------------------------------------------------------------
  key_sample_t sample;
  logic        is_none;
  logic        is_cand;

  assign sample  = classify_keys(keys);
  assign is_none = (sample.cls == CLS_NONE);

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  kp_state_e         state;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  logic              push;

  assign is_cand = (sample.cls == CLS_SINGLE) && (sample.code == cand);

  // The push is decoded combinationally so the FIFO captures the code on the
  // same edge that moves the FSM into HELD.
  assign push = tick && (state == ST_PRESS_WAIT) && is_cand && (cnt == STABLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cand  <= '0;
      cnt   <= '0;
      held  <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (sample.cls == CLS_SINGLE) begin
            cand  <= sample.code;
            cnt   <= CNT_W'(1);
            state <= ST_PRESS_WAIT;
          end
        end
        ST_PRESS_WAIT: begin
          if (is_cand) begin
            if (cnt == STABLE_LAST) begin
              state <= ST_HELD;
              held  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Bounce, release, second key or a different key: abandon.
            state <= ST_IDLE;
          end
        end
        ST_HELD: begin
          // Rollover or extra keys while held are ignored until all keys go up.
          if (is_none) begin
            cnt   <= CNT_W'(1);
            state <= ST_RELEASE_WAIT;
          end
        end
        ST_RELEASE_WAIT: begin
          if (is_none) begin
            if (cnt == STABLE_LAST) begin
              state <= ST_IDLE;
              held  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= ST_HELD;
          end
        end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO and overflow flag
  // --------------------------------------------------------------------------
  logic              fifo_full;
  logic              fifo_empty;
  logic [CODE_W-1:0] fifo_dout;
  logic              pop;
  logic              drop;

  assign key_valid = ~fifo_empty;
  assign key_code  = fifo_empty ? '0 : fifo_dout;
  assign pop       = key_valid & key_ready;
  assign drop      = push & fifo_full & ~pop;

  keypad_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule : keypad_event_ctrl
`default_nettype wire

// File: tb/tb_keypad_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_event_ctrl
//  Purpose  : Directed self-checking bench for keypad_event_ctrl with
//             DIV=4, STABLE_TICKS=3, DEPTH=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_event_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        held;
  logic        overflow;
  logic        ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;   // clock edges since the last edge that sampled rst high

  always #5 clk = ~clk;

  keypad_event_ctrl #(
    .DIV          (4),
    .STABLE_TICKS (3),
    .DEPTH        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys      (keys),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .held      (held),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  endtask

  // Advance to 1 ns past the next edge on which the DUT samples a tick.
  task automatic tick();
    do step(); while (!(cyc > 0 && (cyc % DIV) == 0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_release(input int code);
    keys = 16'(1 << code);
    ticks(3);
    keys = 16'h0000;
    ticks(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    keys      = 16'h0020;
    key_ready = 1'b1;
    ovf_clr   = 1'b0;

    // ---------------- reset ----------------
    step(); step(); step();
    check("rst_valid",    16'(key_valid), 16'd0);
    check("rst_code",     16'(key_code),  16'd0);
    check("rst_held",     16'(held),      16'd0);
    check("rst_overflow", 16'(overflow),  16'd0);
    rst = 1'b0;

    // ---------------- clean press (key 5 still down from reset) ----------------
    ticks(2);
    check("press_t2_valid", 16'(key_valid), 16'd0);
    check("press_t2_held",  16'(held),      16'd0);
    tick();
    check("press_valid", 16'(key_valid), 16'd1);
    check("press_code",  16'(key_code),  16'd5);
    check("press_held",  16'(held),      16'd1);
    step();
    check("press_popped_valid", 16'(key_valid), 16'd0);
    check("press_popped_code",  16'(key_code),  16'd0);
    keys = 16'h0000;
    ticks(2);
    check("release_t2_held", 16'(held), 16'd1);
    tick();
    check("release_held", 16'(held), 16'd0);

    // ---------------- bounce ----------------
    keys = 16'h0020; ticks(2);
    keys = 16'h0000; ticks(1);
    keys = 16'h0020; ticks(2);
    check("bounce_valid", 16'(key_valid), 16'd0);
    check("bounce_held",  16'(held),      16'd0);
    keys = 16'h0000; ticks(1);

    // ---------------- multi-key ----------------
    keys = 16'h0006; ticks(10);
    check("multi_valid", 16'(key_valid), 16'd0);
    check("multi_held",  16'(held),      16'd0);
    keys = 16'h0000; ticks(1);

    // ---------------- overflow ----------------
    key_ready = 1'b0;
    press_release(1);
    press_release(2);
    press_release(3);
    press_release(4);
    check("full_no_ovf", 16'(overflow), 16'd0);
    press_release(5);
    check("ovf_set",   16'(overflow),  16'd1);
    check("ovf_valid", 16'(key_valid), 16'd1);
    check("ovf_head",  16'(key_code),  16'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared", 16'(overflow), 16'd0);

    // Drop coinciding with ovf_clr: the set must win.
    keys = 16'h0040;
    ticks(2);
    ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins", 16'(overflow), 16'd1);
    ovf_clr = 1'b0;
    keys = 16'h0000;
    ticks(3);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared2", 16'(overflow), 16'd0);

    key_ready = 1'b1;
    check("pop0_code", 16'(key_code), 16'd1);
    step();
    check("pop1_code", 16'(key_code), 16'd2);
    step();
    check("pop2_code", 16'(key_code), 16'd3);
    step();
    check("pop3_code", 16'(key_code), 16'd4);
    step();
    check("drained_valid", 16'(key_valid), 16'd0);
    check("drained_code",  16'(key_code),  16'd0);

    // ---------------- reset mid-hold ----------------
    key_ready = 1'b0;
    keys = 16'h0400;
    ticks(3);
    check("hold_a_held", 16'(held),     16'd1);
    check("hold_a_code", 16'(key_code), 16'd10);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_valid", 16'(key_valid), 16'd0);
    check("midrst_held",  16'(held),      16'd0);
    ticks(2);
    check("midrst_t2_valid", 16'(key_valid), 16'd0);
    tick();
    check("midrst_valid2", 16'(key_valid), 16'd1);
    check("midrst_code2",  16'(key_code),  16'd10);
    check("midrst_held2",  16'(held),      16'd1);

    keys = 16'h0000;
    ticks(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_keypad_event_ctrl
`default_nettype wire
